pulse_chan_arb: RTL and testbench

PULSE_CHAN_ARB -- requirements
Module: pulse_chan_arb

---
 rtl/pulse_chan_pkg.sv | 23 ++
 rtl/pulse_chan_arb_rr_pick.sv | 39 +++
 rtl/pulse_chan_arb.sv | 152 +++++++++++++++
 tb/tb_pulse_chan_arb.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_chan_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pulse_chan_pkg
// Purpose  : Shared types and constants for the pulse-channel arbiter.
//            Holds the arbiter FSM state encoding and the watchdog counter
//            width.
// Contents : state_t   - IDLE / ISSUE / WAIT encoding
//            TMO_CNT_W - width of the WAIT-state watchdog counter
// Revision : 1.0  initial release
// ============================================================================
package pulse_chan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int TMO_CNT_W = 16;

endpackage : pulse_chan_pkg
`default_nettype wire

// File: rtl/pulse_chan_arb_rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector. Returns the first set bit
//            of the pending vector, searching upward from last_grant+1 and
//            wrapping from NUM_REQ-1 back to 0. last_grant itself is checked
//            last.
// Ports    : pending    in  NUM_REQ  request vector to choose from
//            last_grant in  ID_W     index granted most recently
//            pick_idx   out ID_W     chosen index (valid only with pick_vld)
//            pick_vld   out 1        at least one pending bit is set
// Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    pick_idx,
  output logic               pick_vld
);

  // Walk offsets from farthest to nearest so the nearest pending requester
  // after last_grant overwrites any earlier candidate.
  always_comb begin
    pick_idx = '0;
    pick_vld = |pending;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int c;
      c = int'(last_grant) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (pending[c]) pick_idx = ID_W'(c);
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/pulse_chan_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pulse_chan_arb
// Purpose  : Round-robin arbiter sharing one pulse-sync channel between
//            NUM_REQ event requesters. Each requester has a sticky pending
//            bit; the FSM grants one requester at a time, fires a one-cycle
//            launch strobe and waits for the channel's completion pulse.
// Ports    : clk        in   1        clock (posedge)
//            reset_     in   1        synchronous active-low reset
//            req_pulse  in   NUM_REQ  one-cycle request per requester
//            req_merged out  NUM_REQ  request arrived while already pending
//            chan_pulse out  1        launch strobe into the channel
//            chan_id    out  ID_W     granted requester id
//            chan_done  in   1        completion from the channel
//            busy       out  1        high in ISSUE and WAIT
//            timeout    out  1        WAIT aborted by the watchdog
// Config   : PULSE_CHAN_ARB_TIMEOUT_EN - when defined, a WAIT watchdog of
//            TIMEOUT_CYC cycles aborts a stalled transfer; otherwise WAIT
//            waits indefinitely and timeout is tied low.
// Revision : 1.0  initial release
// ============================================================================
module pulse_chan_arb
  import pulse_chan_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic [NUM_REQ-1:0] req_pulse,
  output logic [NUM_REQ-1:0] req_merged,
  output logic               chan_pulse,
  output logic [ID_W-1:0]    chan_id,
  input  logic               chan_done,
  output logic               busy,
  output logic               timeout
);

  state_t             r_state;
  logic [NUM_REQ-1:0] r_pending;
  logic [ID_W-1:0]    r_last_grant;
  logic [ID_W-1:0]    r_chan_id;
  logic               r_chan_pulse;
  logic               r_busy;
  logic [NUM_REQ-1:0] r_merged;

  logic [NUM_REQ-1:0] w_clear;
  logic [NUM_REQ-1:0] w_pending_nxt;
  logic [NUM_REQ-1:0] w_merged;
  logic [ID_W-1:0]    w_pick_idx;
  logic               w_pick_vld;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .pending    (r_pending),
    .last_grant (r_last_grant),
    .pick_idx   (w_pick_idx),
    .pick_vld   (w_pick_vld)
  );

  // The granted requester's pending bit is released during the ISSUE cycle.
  // A new request in that same cycle re-arms it (set wins) and is not
  // treated as a merge, since the old event is being consumed.
  always_comb begin
    w_clear = '0;
    if (r_state == ST_ISSUE) w_clear = NUM_REQ'(1) << r_chan_id;
    w_pending_nxt = (r_pending & ~w_clear) | req_pulse;
    w_merged      = req_pulse & r_pending & ~w_clear;
  end

`ifdef PULSE_CHAN_ARB_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] r_wdog;
  logic                 r_timeout;
`endif

  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_state      <= ST_IDLE;
      r_pending    <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_chan_id    <= '0;
      r_chan_pulse <= 1'b0;
      r_busy       <= 1'b0;
      r_merged     <= '0;
`ifdef PULSE_CHAN_ARB_TIMEOUT_EN
      r_wdog       <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_pending    <= w_pending_nxt;
      r_merged     <= w_merged;
      r_chan_pulse <= 1'b0;
`ifdef PULSE_CHAN_ARB_TIMEOUT_EN
      r_timeout    <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_chan_id    <= w_pick_idx;
            r_chan_pulse <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef PULSE_CHAN_ARB_TIMEOUT_EN
          r_wdog  <= '0;
`endif
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (chan_done) begin
            r_last_grant <= r_chan_id;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
`ifdef PULSE_CHAN_ARB_TIMEOUT_EN
          end else if (r_wdog == TMO_CNT_W'(TIMEOUT_CYC - 1)) begin
            // Abandon the transfer; the request is not re-queued.
            r_last_grant <= r_chan_id;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
`endif
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_merged = r_merged;
  assign chan_pulse = r_chan_pulse;
  assign chan_id    = r_chan_id;
  assign busy       = r_busy;
`ifdef PULSE_CHAN_ARB_TIMEOUT_EN
  assign timeout    = r_timeout;
`else
  assign timeout    = 1'b0;
`endif

endmodule : pulse_chan_arb
`default_nettype wire

// File: tb/tb_pulse_chan_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pulse_chan_arb
// Purpose  : Directed self-checking bench for pulse_chan_arb (NUM_REQ=4,
//            TIMEOUT_CYC=8). Inputs change 1ns after the rising edge and
//            outputs are checked at that point, well away from the edge.
// Config   : PULSE_CHAN_ARB_TIMEOUT_EN selects the watchdog scenario.
// Revision : 1.0  initial release
// ============================================================================
module tb_pulse_chan_arb;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic               clk;
  logic               reset_;
  logic [NUM_REQ-1:0] req_pulse;
  logic [NUM_REQ-1:0] req_merged;
  logic               chan_pulse;
  logic [ID_W-1:0]    chan_id;
  logic               chan_done;
  logic               busy;
  logic               timeout;

  int total;
  int bad;

  pulse_chan_arb #(
    .NUM_REQ     (NUM_REQ),
    .ID_W        (ID_W),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk        (clk),
    .reset_     (reset_),
    .req_pulse  (req_pulse),
    .req_merged (req_merged),
    .chan_pulse (chan_pulse),
    .chan_id    (chan_id),
    .chan_done  (chan_done),
    .busy       (busy),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_    = 1'b0;
    req_pulse = '0;
    chan_done = 1'b0;
    tick();
    tick();
    reset_ = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (chan_pulse !== 1'b0) begin bad++; $display("FAIL reset_chan_pulse got=%b exp=0", chan_pulse); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (chan_id !== 2'd0) begin bad++; $display("FAIL reset_chan_id got=%0d exp=0", chan_id); end
    total++; if (req_merged !== 4'b0000) begin bad++; $display("FAIL reset_merged got=%b exp=0000", req_merged); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
  endtask

  task automatic test_single();
    do_reset();
    req_pulse = 4'b0100;
    tick();
    req_pulse = '0;
    total++; if (chan_pulse !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_k1 pulse=%b busy=%b exp 0/0", chan_pulse, busy); end
    tick();
    total++; if (chan_pulse !== 1'b1) begin bad++; $display("FAIL single_pulse got=%b exp=1", chan_pulse); end
    total++; if (chan_id !== 2'd2) begin bad++; $display("FAIL single_id got=%0d exp=2", chan_id); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_issue got=%b exp=1", busy); end
    tick();
    total++; if (chan_pulse !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_wait pulse=%b busy=%b exp 0/1", chan_pulse, busy); end
    repeat (6) tick();
    chan_done = 1'b1;
    tick();
    chan_done = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_done_busy got=%b exp=0", busy); end
    repeat (3) tick();
    total++; if (chan_pulse !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_quiet pulse=%b busy=%b exp 0/0", chan_pulse, busy); end
  endtask

  // Four simultaneous requests: grants 0,1,2,3 in order, each launch exactly
  // one cycle after the IDLE cycle that follows the previous completion.
  task automatic test_fairness();
    do_reset();
    req_pulse = 4'b1111;
    tick();
    req_pulse = '0;
    for (int e = 0; e < 4; e++) begin
      int n;
      int extra;
      n = 0;
      while (chan_pulse !== 1'b1 && n < 10) begin tick(); n++; end
      total++; if (chan_pulse !== 1'b1 || n !== 1) begin bad++; $display("FAIL fair_latency grant=%0d waited=%0d exp=1 pulse=%b", e, n, chan_pulse); end
      total++; if (chan_id !== ID_W'(e)) begin bad++; $display("FAIL fair_order got=%0d exp=%0d", chan_id, e); end
      extra = 0;
      repeat (3) begin tick(); if (chan_pulse === 1'b1) extra++; end
      total++; if (extra !== 0) begin bad++; $display("FAIL fair_extra_pulse got=%0d exp=0", extra); end
      chan_done = 1'b1;
      tick();
      chan_done = 1'b0;
      total++; if (busy !== 1'b0 || chan_pulse !== 1'b0) begin bad++; $display("FAIL fair_idle busy=%b pulse=%b exp 0/0", busy, chan_pulse); end
    end
    tick();
    total++; if (chan_pulse !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL fair_drained pulse=%b busy=%b exp 0/0", chan_pulse, busy); end
  endtask

  task automatic test_merge();
    int merges;
    int pulses;
    do_reset();
    req_pulse = 4'b0001;
    tick();
    req_pulse = '0;
    tick();                         // ISSUE for id 0
    tick();                         // WAIT
    merges = 0;
    req_pulse = 4'b0010;
    tick();
    req_pulse = '0;
    total++; if (req_merged !== 4'b0000) begin bad++; $display("FAIL merge_first got=%b exp=0000", req_merged); end
    tick();
    req_pulse = 4'b0010;
    tick();
    req_pulse = '0;
    total++; if (req_merged !== 4'b0010) begin bad++; $display("FAIL merge_flag got=%b exp=0010", req_merged); end
    tick();
    total++; if (req_merged !== 4'b0000) begin bad++; $display("FAIL merge_one_cycle got=%b exp=0000", req_merged); end
    chan_done = 1'b1;
    tick();
    chan_done = 1'b0;
    pulses = 0;
    repeat (4) begin
      tick();
      if (chan_pulse === 1'b1) begin
        pulses++;
        total++; if (chan_id !== 2'd1) begin bad++; $display("FAIL merge_id got=%0d exp=1", chan_id); end
      end
      if (req_merged !== 4'b0000) merges++;
    end
    chan_done = 1'b1;
    tick();
    chan_done = 1'b0;
    repeat (5) begin tick(); if (chan_pulse === 1'b1) pulses++; end
    total++; if (pulses !== 1) begin bad++; $display("FAIL merge_pulse_count got=%0d exp=1", pulses); end
    total++; if (merges !== 0) begin bad++; $display("FAIL merge_spurious got=%0d exp=0", merges); end
  endtask

  task automatic test_set_wins();
    do_reset();
    req_pulse = 4'b1000;
    tick();
    req_pulse = '0;
    tick();
    total++; if (chan_pulse !== 1'b1 || chan_id !== 2'd3) begin bad++; $display("FAIL setwin_first pulse=%b id=%0d exp 1/3", chan_pulse, chan_id); end
    req_pulse = 4'b1000;            // arrives in the ISSUE cycle
    tick();
    req_pulse = '0;
    total++; if (req_merged !== 4'b0000) begin bad++; $display("FAIL setwin_no_merge got=%b exp=0000", req_merged); end
    total++; if (chan_pulse !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL setwin_wait pulse=%b busy=%b exp 0/1", chan_pulse, busy); end
    chan_done = 1'b1;
    tick();
    chan_done = 1'b0;
    tick();
    total++; if (chan_pulse !== 1'b1 || chan_id !== 2'd3) begin bad++; $display("FAIL setwin_second pulse=%b id=%0d exp 1/3", chan_pulse, chan_id); end
    chan_done = 1'b1;
    tick();
    tick();
    chan_done = 1'b0;
    repeat (3) tick();
    total++; if (chan_pulse !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL setwin_drained pulse=%b busy=%b exp 0/0", chan_pulse, busy); end
  endtask

  task automatic test_reset_mid_wait();
    int activity;
    do_reset();
    req_pulse = 4'b0001;
    tick();
    req_pulse = '0;
    tick();                         // ISSUE id 0
    tick();                         // WAIT
    req_pulse = 4'b0101;
    tick();
    req_pulse = 4'b1111;            // discarded because reset is active
    reset_ = 1'b0;
    tick();
    req_pulse = '0;
    reset_ = 1'b1;
    total++; if ({chan_pulse, busy, timeout, req_merged, chan_id} !== 9'd0) begin
      bad++; $display("FAIL rst_wait_outputs pulse=%b busy=%b to=%b merged=%b id=%0d exp all 0", chan_pulse, busy, timeout, req_merged, chan_id);
    end
    chan_done = 1'b1;
    tick();
    chan_done = 1'b0;
    activity = 0;
    repeat (6) begin tick(); if (chan_pulse !== 1'b0 || busy !== 1'b0) activity++; end
    total++; if (activity !== 0) begin bad++; $display("FAIL rst_wait_quiet active_cycles=%0d exp=0", activity); end
  endtask

`ifdef PULSE_CHAN_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    do_reset();
    req_pulse = 4'b0011;
    tick();
    req_pulse = '0;
    tick();
    total++; if (chan_pulse !== 1'b1 || chan_id !== 2'd0) begin bad++; $display("FAIL tmo_grant0 pulse=%b id=%0d exp 1/0", chan_pulse, chan_id); end
    early = 0;
    repeat (8) begin tick(); if (timeout !== 1'b0 || busy !== 1'b1) early++; end
    total++; if (early !== 0) begin bad++; $display("FAIL tmo_early bad_cycles=%0d exp=0", early); end
    tick();
    total++; if (timeout !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL tmo_fire to=%b busy=%b exp 1/0", timeout, busy); end
    tick();
    total++; if (chan_pulse !== 1'b1 || chan_id !== 2'd1 || timeout !== 1'b0) begin
      bad++; $display("FAIL tmo_next pulse=%b id=%0d to=%b exp 1/1/0", chan_pulse, chan_id, timeout);
    end
    repeat (8) tick();              // last WAIT cycle before expiry
    chan_done = 1'b1;
    tick();
    chan_done = 1'b0;
    total++; if (timeout !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL tmo_done_wins to=%b busy=%b exp 0/0", timeout, busy); end
  endtask
`else
  task automatic test_no_timeout();
    int lost;
    do_reset();
    req_pulse = 4'b0010;
    tick();
    req_pulse = '0;
    tick();
    lost = 0;
    repeat (30) begin tick(); if (busy !== 1'b1 || timeout !== 1'b0) lost++; end
    total++; if (lost !== 0) begin bad++; $display("FAIL notmo_wait bad_cycles=%0d exp=0", lost); end
    chan_done = 1'b1;
    tick();
    chan_done = 1'b0;
    total++; if (busy !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL notmo_done busy=%b to=%b exp 0/0", busy, timeout); end
  endtask
`endif

  initial begin
    total     = 0;
    bad       = 0;
    reset_    = 1'b0;
    req_pulse = '0;
    chan_done = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_merge();
    test_set_wins();
    test_reset_mid_wait();
`ifdef PULSE_CHAN_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit reached without completion");
    $fatal(1);
  end

endmodule : tb_pulse_chan_arb
`default_nettype wire
